fetch_unit: RTL and testbench

//   Program-counter / fetch controller directly upstream of the instruction ROM.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/jump_lut.sv | 33 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller and its jump-target LUT.
package fetch_pkg;

  localparam int ADDR_W    = 16;
  localparam int OFF_W     = 8;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_IDX_W = 4;
  localparam int CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  // Saturating increment used by the RUN-cycle counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + CNT_W'(1);
  endfunction

endpackage

// File: rtl/jump_lut.sv
// Absolute jump-target table: synchronous write, combinational read, clears on reset.
module jump_lut
  import fetch_pkg::*;
#(
  parameter int DEPTH  = LUT_DEPTH,
  parameter int IDX_W  = LUT_IDX_W,
  parameter int DATA_W = ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reading straight from the registers gives read-before-write on a same-index collision.
  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and IDLE/RUN/HALTED control for the instruction ROM fetch port.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr_in,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic                 branch_rel,
  input  logic [OFF_W-1:0]     branch_off,
  input  logic                 halt,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [ADDR_W-1:0]    lut_wdata,
  output logic [ADDR_W-1:0]    pc_out,
  output logic                 fetch_valid,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count,
  output fetch_state_t         state_dbg
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] lut_target;
  logic [ADDR_W-1:0] rel_target;

  jump_lut #(
    .DEPTH  (LUT_DEPTH),
    .IDX_W  (LUT_IDX_W),
    .DATA_W (ADDR_W)
  ) u_jump_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .waddr (lut_waddr),
    .wdata (lut_wdata),
    .raddr (branch_off[LUT_IDX_W-1:0]),
    .rdata (lut_target)
  );

  assign rel_target = pc_q + ADDR_W'(signed'(branch_off));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr_in;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (start) begin
          pc_d  = start_addr_in;
          cnt_d = '0;
        end else begin
          // Halt and stall cycles are still RUN cycles and are counted.
          cnt_d = sat_inc(cnt_q);
          if (halt) begin
            state_d = HALTED;
          end else if (!stall) begin
            if (branch_taken) begin
              pc_d = branch_rel ? rel_target : lut_target;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: fetch_valid qualifies pc_out; the ROM has no ready and always accepts.
  assign pc_out      = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign done        = (state_q == HALTED);
  assign cycle_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reference model pushes expected outputs, a negedge monitor pops and compares.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int EW = 36;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [15:0]  start_addr_in;
  logic         stall;
  logic         branch_taken;
  logic         branch_rel;
  logic [7:0]   branch_off;
  logic         halt;
  logic         lut_we;
  logic [3:0]   lut_waddr;
  logic [15:0]  lut_wdata;
  logic [15:0]  pc_out;
  logic         fetch_valid;
  logic         done;
  logic [15:0]  cycle_count;
  fetch_state_t state_dbg;

  fetch_unit #(.START_ADDR(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr_in (start_addr_in),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_rel    (branch_rel),
    .branch_off    (branch_off),
    .halt          (halt),
    .lut_we        (lut_we),
    .lut_waddr     (lut_waddr),
    .lut_wdata     (lut_wdata),
    .pc_out        (pc_out),
    .fetch_valid   (fetch_valid),
    .done          (done),
    .cycle_count   (cycle_count),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: 0 = idle, 1 = running, 2 = halted
  int m_state;
  int m_pc;
  int m_cnt;
  int m_lut[16];

  function automatic void check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [EW-1:0] model_word();
    logic [1:0] st;
    st = 2'(m_state);
    return {st, (m_state == 1), (m_state == 2), 16'(m_pc), 16'(m_cnt)};
  endfunction

  // driver tasks
  task automatic clr();
    reset = 1'b0; start = 1'b0; start_addr_in = '0; stall = 1'b0;
    branch_taken = 1'b0; branch_rel = 1'b0; branch_off = '0; halt = 1'b0;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
  endtask

  // Advance the model by the rules on the current inputs, clock once, queue the expectation.
  task automatic tick();
    int tgt;
    if (reset) begin
      m_state = 0; m_pc = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 0;
    end else begin
      if (branch_rel) tgt = (m_pc + int'($signed(branch_off))) & 16'hFFFF;
      else            tgt = m_lut[branch_off[3:0]];
      if (m_state != 1) begin
        if (start) begin m_state = 1; m_pc = start_addr_in; m_cnt = 0; end
      end else if (start) begin
        m_pc = start_addr_in; m_cnt = 0;
      end else begin
        if (m_cnt < 65535) m_cnt++;
        if (halt)              m_state = 2;
        else if (stall)        m_pc = m_pc;
        else if (branch_taken) m_pc = tgt;
        else                   m_pc = (m_pc + 1) % 65536;
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(model_word());
  endtask

  task automatic pc_is(input string name, input logic [15:0] exp);
    check(name, EW'(pc_out), EW'(exp));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check("scoreboard", {state_dbg, fetch_valid, done, pc_out, cycle_count}, exp_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr();
    reset = 1'b1;
    tick(); tick();
    check("reset_state", {state_dbg, fetch_valid, done, pc_out, cycle_count}, 36'h0);

    // start at 0x0040 then free-run
    clr(); start = 1'b1; start_addr_in = 16'h0040; tick();
    pc_is("start_pc", 16'h0040);
    check("start_valid", EW'(fetch_valid), EW'(1'b1));
    clr(); tick(); pc_is("inc_41", 16'h0041);
    tick(); pc_is("inc_42", 16'h0042);
    tick(); pc_is("inc_43", 16'h0043);

    // relative branches, negative and maximum positive offset
    start = 1'b1; start_addr_in = 16'h0050; tick(); clr();
    branch_taken = 1'b1; branch_rel = 1'b1; branch_off = 8'hF0; tick(); clr();
    pc_is("rel_neg", 16'h0040);
    start = 1'b1; start_addr_in = 16'h0050; tick(); clr();
    branch_taken = 1'b1; branch_rel = 1'b1; branch_off = 8'h7F; tick(); clr();
    pc_is("rel_pos", 16'h00CF);

    // LUT jumps and read-before-write
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 16'h1234; tick(); clr();
    branch_taken = 1'b1; branch_off = 8'd3; tick();
    pc_is("abs_jump", 16'h1234);
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 16'h5555; tick(); clr();
    pc_is("abs_rbw_old", 16'h1234);
    branch_taken = 1'b1; branch_off = 8'd3; tick(); clr();
    pc_is("abs_new", 16'h5555);

    // wrap and stall priority over branch
    start = 1'b1; start_addr_in = 16'hFFFF; tick(); clr();
    tick(); pc_is("wrap", 16'h0000);
    stall = 1'b1; branch_taken = 1'b1; branch_rel = 1'b1; branch_off = 8'h10; tick(); clr();
    pc_is("stall_hold", 16'h0000);

    // halt beats branch; halted ignores branch/stall; restart clears counter
    start = 1'b1; start_addr_in = 16'h0020; tick(); clr();
    halt = 1'b1; branch_taken = 1'b1; branch_rel = 1'b1; branch_off = 8'h05; tick(); clr();
    check("halt_done", EW'({done, fetch_valid}), EW'(2'b10));
    pc_is("halt_pc", 16'h0020);
    branch_taken = 1'b1; branch_rel = 1'b1; branch_off = 8'h05; stall = 1'b1; tick(); clr();
    pc_is("halted_frozen", 16'h0020);
    start = 1'b1; start_addr_in = 16'h0000; tick(); clr();
    check("restart", EW'({fetch_valid, cycle_count}), EW'({1'b1, 16'h0000}));

    // reset beats start mid-run and clears the LUT
    tick(); tick();
    reset = 1'b1; start = 1'b1; start_addr_in = 16'h0777; tick(); clr();
    check("reset_mid_run", {state_dbg, fetch_valid, done, pc_out, cycle_count}, 36'h0);
    start = 1'b1; start_addr_in = 16'h0100; tick(); clr();
    branch_taken = 1'b1; branch_off = 8'd3; tick(); clr();
    pc_is("lut_cleared", 16'h0000);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 99) == 0);
      start         = ($urandom_range(0, 15) == 0);
      start_addr_in = 16'($urandom);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_rel    = 1'($urandom);
      branch_off    = 8'($urandom);
      halt          = ($urandom_range(0, 24) == 0);
      lut_we        = ($urandom_range(0, 3) == 0);
      lut_waddr     = 4'($urandom);
      lut_wdata     = 16'($urandom);
      tick();
    end
    clr();

    // counter saturation: hold the PC with stall long enough to pass 16'hFFFF
    start = 1'b1; start_addr_in = 16'h0A00; tick(); clr();
    stall = 1'b1;
    for (int n = 0; n < 65534; n++) tick();
    check("cnt_fffe", EW'(cycle_count), EW'(16'hFFFE));
    tick(); tick(); tick();
    check("cnt_sat", EW'(cycle_count), EW'(16'hFFFF));
    pc_is("cnt_pc_held", 16'h0A00);
    clr();

    @(negedge clk);
    #1;
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
